sobel_frame_engine: RTL and testbench

- Parametrised successor to the single-window edge detector.
- Streams a whole greyscale frame from the framestore through a 3x3 Sobel window held in on-chip line buffers, processing LANES pixels per word.
- Writes the thresholded edge map back to a destination frame.
- Sits between the command port (req/ack/busy) and the framestore data port (de_*), with real de_ack flow control and a configurable image geometry.

---
 rtl/sobel_frame_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_sobel_frame_engine.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_engine.sv
// Frame-level 3x3 Sobel edge engine: streams a source frame through line buffers
// and writes a thresholded edge map to a destination frame over the de_* port.
module sobel_frame_engine #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned IMG_W_WORDS = 80,
    parameter int unsigned IMG_H       = 240,
    parameter int unsigned ADDR_W      = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    output logic                 ack,
    output logic                 busy,
    input  logic [ADDR_W-1:0]    src_base,
    input  logic [ADDR_W-1:0]    dst_base,
    input  logic [11:0]          threshold,
    output logic                 de_req,
    input  logic                 de_ack,
    output logic [ADDR_W-1:0]    de_addr,
    output logic [LANES-1:0]     de_nbyte,
    output logic                 de_rnw,
    output logic [8*LANES-1:0]   de_w_data,
    input  logic [8*LANES-1:0]   de_r_data
);
    localparam int unsigned DATA_W = 8 * LANES;
    localparam int unsigned XW     = $clog2(IMG_W_WORDS);
    localparam int unsigned YW     = $clog2(IMG_H);
    localparam int unsigned EXT_W  = DATA_W + 16;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_WR, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [11:0]         thr_q, thr_d;
    logic                w1_done_q, w1_done_d, w2_done_q, w2_done_d;
    logic                ack_q, ack_d, busy_q, busy_d;
    logic                de_req_q, de_req_d, de_rnw_q, de_rnw_d;
    logic [ADDR_W-1:0]   de_addr_q, de_addr_d;
    logic [LANES-1:0]    de_nbyte_q, de_nbyte_d;
    logic [DATA_W-1:0]   de_w_data_q, de_w_data_d;

    // Window columns [0]=oldest .. [2]=newest; rows: top = y-2, mid = y-1, bot = y
    logic [DATA_W-1:0]   top_q [3];
    logic [DATA_W-1:0]   mid_q [3];
    logic [DATA_W-1:0]   bot_q [3];
    logic [DATA_W-1:0]   lb1_q [IMG_W_WORDS];
    logic [DATA_W-1:0]   lb2_q [IMG_W_WORDS];

    logic                rd_fire_c, need_w1_c, need_w2_c, edge_sel_c, last_wr_c;
    logic [EXT_W-1:0]    ext_t_c, ext_m_c, ext_b_c;
    logic [DATA_W-1:0]   res_c;

    function automatic logic signed [11:0] sx(input logic [7:0] p);
        return signed'({4'b0000, p});
    endfunction

    // Triples hold {right, centre, left} pixels of one row for one output lane
    function automatic logic [11:0] sobel_mag(input logic [23:0] t, input logic [23:0] m,
                                              input logic [23:0] b);
        logic signed [11:0] gx, gy;
        logic [11:0]        ax, ay;
        gx = (sx(t[23:16]) + (sx(m[23:16]) <<< 1) + sx(b[23:16]))
           - (sx(t[7:0])   + (sx(m[7:0])   <<< 1) + sx(b[7:0]));
        gy = (sx(b[7:0]) + (sx(b[15:8]) <<< 1) + sx(b[23:16]))
           - (sx(t[7:0]) + (sx(t[15:8]) <<< 1) + sx(t[23:16]));
        ax = gx[11] ? 12'(-gx) : 12'(gx);
        ay = gy[11] ? 12'(-gy) : 12'(gy);
        return ax + ay;
    endfunction

    assign rd_fire_c  = (state_q == S_RD) && de_ack;
    assign need_w1_c  = (y_q >= YW'(2)) && (x_q != '0) && !w1_done_q;
    assign need_w2_c  = (y_q >= YW'(2)) && (x_q == XW'(IMG_W_WORDS - 1)) && !w2_done_q;
    assign edge_sel_c = !need_w1_c;
    assign last_wr_c  = (x_q == XW'(IMG_W_WORDS - 1)) && (y_q == YW'(IMG_H - 1)) && w2_done_q;

    // Rows widened by one neighbour pixel on each side; the edge word has a zero right word
    always_comb begin
        if (edge_sel_c) begin
            ext_t_c = {8'h00, top_q[2], top_q[1][DATA_W-1 -: 8]};
            ext_m_c = {8'h00, mid_q[2], mid_q[1][DATA_W-1 -: 8]};
            ext_b_c = {8'h00, bot_q[2], bot_q[1][DATA_W-1 -: 8]};
        end else begin
            ext_t_c = {top_q[2][7:0], top_q[1], top_q[0][DATA_W-1 -: 8]};
            ext_m_c = {mid_q[2][7:0], mid_q[1], mid_q[0][DATA_W-1 -: 8]};
            ext_b_c = {bot_q[2][7:0], bot_q[1], bot_q[0][DATA_W-1 -: 8]};
        end
    end

    always_comb begin
        res_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (!(i == 0 && !edge_sel_c && x_q == XW'(1)) &&
                !(i == int'(LANES) - 1 && edge_sel_c) &&
                (sobel_mag(ext_t_c[8*i +: 24], ext_m_c[8*i +: 24], ext_b_c[8*i +: 24]) > thr_q))
                res_c[8*i +: 8] = 8'hFF;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        thr_d       = thr_q;
        w1_done_d   = w1_done_q;
        w2_done_d   = w2_done_q;
        ack_d       = 1'b0;
        busy_d      = busy_q;
        de_req_d    = de_req_q;
        de_rnw_d    = de_rnw_q;
        de_addr_d   = de_addr_q;
        de_nbyte_d  = de_nbyte_q;
        de_w_data_d = de_w_data_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    ack_d      = 1'b1;
                    busy_d     = 1'b1;
                    thr_d      = threshold;
                    x_d        = '0;
                    y_d        = '0;
                    rd_ptr_d   = src_base;
                    wr_ptr_d   = dst_base + ADDR_W'(IMG_W_WORDS);
                    w1_done_d  = 1'b0;
                    w2_done_d  = 1'b0;
                    de_req_d   = 1'b1;
                    de_rnw_d   = 1'b1;
                    de_addr_d  = src_base;
                    de_nbyte_d = '1;
                    state_d    = S_RD;
                end
            end
            S_RD: begin
                if (de_ack) begin
                    de_req_d = 1'b0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (need_w1_c || need_w2_c) begin
                    de_req_d    = 1'b1;
                    de_rnw_d    = 1'b0;
                    de_addr_d   = wr_ptr_q;
                    wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                    de_w_data_d = res_c;
                    w1_done_d   = 1'b1;
                    w2_done_d   = !need_w1_c;
                    state_d     = S_WR;
                end else begin
                    w1_done_d = 1'b0;
                    w2_done_d = 1'b0;
                    if (x_q == XW'(IMG_W_WORDS - 1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
                    de_req_d  = 1'b1;
                    de_rnw_d  = 1'b1;
                    de_addr_d = rd_ptr_q + ADDR_W'(1);
                    state_d   = S_RD;
                end
            end
            S_WR: begin
                if (de_ack) begin
                    de_req_d = 1'b0;
                    if (last_wr_c) begin
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            thr_q       <= '0;
            w1_done_q   <= 1'b0;
            w2_done_q   <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            de_req_q    <= 1'b0;
            de_rnw_q    <= 1'b0;
            de_addr_q   <= '0;
            de_nbyte_q  <= '0;
            de_w_data_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            thr_q       <= thr_d;
            w1_done_q   <= w1_done_d;
            w2_done_q   <= w2_done_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            de_req_q    <= de_req_d;
            de_rnw_q    <= de_rnw_d;
            de_addr_q   <= de_addr_d;
            de_nbyte_q  <= de_nbyte_d;
            de_w_data_q <= de_w_data_d;
        end
    end

    // Window shift and line-buffer update on each read beat (contents need no reset)
    always_ff @(posedge clk) begin
        if (rd_fire_c) begin
            top_q[0]   <= top_q[1];
            top_q[1]   <= top_q[2];
            top_q[2]   <= lb2_q[x_q];
            mid_q[0]   <= mid_q[1];
            mid_q[1]   <= mid_q[2];
            mid_q[2]   <= lb1_q[x_q];
            bot_q[0]   <= bot_q[1];
            bot_q[1]   <= bot_q[2];
            bot_q[2]   <= de_r_data;
            lb2_q[x_q] <= lb1_q[x_q];
            lb1_q[x_q] <= de_r_data;
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign de_req    = de_req_q;
    assign de_rnw    = de_rnw_q;
    assign de_addr   = de_addr_q;
    assign de_nbyte  = de_nbyte_q;
    assign de_w_data = de_w_data_q;

endmodule

// File: tb/tb_sobel_frame_engine.sv
// Bench for sobel_frame_engine on a 4x4-word frame: framestore responder with
// configurable ack latency and a pixel-level Sobel reference model.
module tb_sobel_frame_engine;
    localparam int unsigned L = 4, W = 4, H = 4, AW = 18;

    logic          clk, rst_n, req, ack, busy;
    logic [AW-1:0] src_base, dst_base, de_addr;
    logic [11:0]   threshold;
    logic          de_req, de_ack, de_rnw;
    logic [L-1:0]  de_nbyte;
    logic [31:0]   de_w_data, de_r_data;

    sobel_frame_engine #(.LANES(L), .IMG_W_WORDS(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .busy(busy),
        .src_base(src_base), .dst_base(dst_base), .threshold(threshold),
        .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
        .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data)
    );

    int n_pass = 0, n_total = 0, cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]   img_w [16];
    logic [AW-1:0] cur_src;
    int            lat;
    bit            lat_rand;
    logic [AW-1:0] rd_q [$];
    logic [AW-1:0] wa_q [$];
    logic [31:0]   wd_q [$];
    int            stab_err, drop_err, nb_err, last_wr_cyc;

    // Framestore responder: one outstanding transaction, ack after lat waiting cycles
    initial begin : responder
        bit            in_txn;
        int            cnt, cur_lat;
        logic [AW-1:0] c_addr, idx;
        logic          c_rnw;
        logic [31:0]   c_wd;
        de_ack = 1'b0;
        de_r_data = '0;
        in_txn = 1'b0;
        cnt = 0;
        cur_lat = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                de_ack = 1'b0;
                in_txn = 1'b0;
                cnt = 0;
            end else if (de_ack) begin
                de_ack = 1'b0;
                if (de_req) drop_err++;
            end else if (de_req) begin
                if (de_nbyte !== 4'hF) nb_err++;
                if (!in_txn) begin
                    in_txn = 1'b1;
                    cnt = 0;
                    c_addr = de_addr;
                    c_rnw = de_rnw;
                    c_wd = de_w_data;
                    cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat;
                end else if (de_addr !== c_addr || de_rnw !== c_rnw || de_w_data !== c_wd) begin
                    stab_err++;
                end
                if (cnt == cur_lat) begin
                    de_ack = 1'b1;
                    in_txn = 1'b0;
                    if (de_rnw) begin
                        rd_q.push_back(de_addr);
                        idx = de_addr - cur_src;
                        de_r_data = (idx < 18'd16) ? img_w[idx[3:0]] : 32'hDEADBEEF;
                    end else begin
                        wa_q.push_back(de_addr);
                        wd_q.push_back(de_w_data);
                        last_wr_cyc = cyc;
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    function automatic int px(int r, int c);
        logic [31:0] w;
        if (r < 0 || r > 3 || c < 0 || c > 15) return 0;
        w = img_w[r*4 + c/4];
        return int'((w >> (8 * (c % 4))) & 32'hFF);
    endfunction

    // Reference: output word (row, col) from the pixel grid, borders forced to zero
    function automatic logic [31:0] exp_word(int row, int col, logic [11:0] thr);
        logic [31:0] w;
        int c, gx, gy, mag;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            c = col*4 + i;
            gx = (px(row-1, c+1) + 2*px(row, c+1) + px(row+1, c+1))
               - (px(row-1, c-1) + 2*px(row, c-1) + px(row+1, c-1));
            gy = (px(row+1, c-1) + 2*px(row+1, c) + px(row+1, c+1))
               - (px(row-1, c-1) + 2*px(row-1, c) + px(row-1, c+1));
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            if (c != 0 && c != 15 && mag > int'(thr)) w[8*i +: 8] = 8'hFF;
        end
        return w;
    endfunction

    task automatic run_frame(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input logic [11:0] thr, input bit req_busy,
                             output int n_ack, output int fall_cyc, output bit timed_out);
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        stab_err = 0; drop_err = 0; nb_err = 0; last_wr_cyc = -10;
        cur_src = src;
        n_ack = 0; fall_cyc = -1; timed_out = 1'b1;
        @(negedge clk);
        src_base = src; dst_base = dst; threshold = thr; req = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0) req = 1'b0;
            if (ack) n_ack++;
            if (req_busy && i == 6) req = 1'b1;
            if (req_busy && i == 8) req = 1'b0;
            if (i > 0 && !busy) begin
                fall_cyc = cyc;
                timed_out = 1'b0;
                break;
            end
        end
        req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; src_base = '0; dst_base = '0; threshold = '0;
        lat = 1; lat_rand = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({ack, busy, de_req, de_rnw} !== 4'b0) $display("FAIL reset_ctrl got %b want 0000", {ack, busy, de_req, de_rnw});
        else n_pass++;
        n_total++;
        if (de_addr !== '0 || de_nbyte !== '0 || de_w_data !== '0)
            $display("FAIL reset_bus got addr=%h nbyte=%h wdata=%h want 0", de_addr, de_nbyte, de_w_data);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_uniform();
        int na, fc; bit to;
        for (int k = 0; k < 16; k++) img_w[k] = 32'h40404040;
        lat = 1; lat_rand = 1'b0;
        run_frame(18'h100, 18'h200, 12'd10, 1'b0, na, fc, to);
        n_total++; if (to) $display("FAIL uniform_timeout got busy stuck want fall"); else n_pass++;
        n_total++; if (rd_q.size() != 16) $display("FAIL uniform_nreads got %0d want 16", rd_q.size()); else n_pass++;
        for (int k = 0; k < rd_q.size(); k++) begin
            n_total++;
            if (rd_q[k] !== 18'(18'h100 + k)) $display("FAIL uniform_raddr got %h want %h", rd_q[k], 18'(18'h100 + k));
            else n_pass++;
        end
        n_total++; if (wa_q.size() != 8) $display("FAIL uniform_nwrites got %0d want 8", wa_q.size()); else n_pass++;
        for (int k = 0; k < wa_q.size(); k++) begin
            n_total++;
            if (wa_q[k] !== 18'(18'h204 + k) || wd_q[k] !== 32'h0)
                $display("FAIL uniform_write got %h:%h want %h:00000000", wa_q[k], wd_q[k], 18'(18'h204 + k));
            else n_pass++;
        end
        n_total++; if (na != 1) $display("FAIL uniform_ack_pulses got %0d want 1", na); else n_pass++;
        n_total++; if (fc != last_wr_cyc + 1) $display("FAIL uniform_busy_fall got %0d want %0d", fc, last_wr_cyc + 1); else n_pass++;
        n_total++;
        if (stab_err + drop_err + nb_err != 0) $display("FAIL uniform_handshake got %0d/%0d/%0d want 0/0/0", stab_err, drop_err, nb_err);
        else n_pass++;
    endtask

    task automatic test_vertical_step();
        int na, fc; bit to;
        logic [31:0] want [4];
        want[0] = 32'h0; want[1] = 32'hFF000000; want[2] = 32'h000000FF; want[3] = 32'h0;
        for (int k = 0; k < 16; k++) img_w[k] = (k % 4 < 2) ? 32'h0 : 32'hFFFFFFFF;
        lat = 1; lat_rand = 1'b0;
        run_frame(18'h100, 18'h200, 12'd10, 1'b0, na, fc, to);
        n_total++; if (wa_q.size() != 8) $display("FAIL step_nwrites got %0d want 8", wa_q.size()); else n_pass++;
        for (int k = 0; k < wa_q.size(); k++) begin
            n_total++;
            if (wa_q[k] !== 18'(18'h204 + k) || wd_q[k] !== want[k % 4])
                $display("FAIL step_write got %h:%h want %h:%h", wa_q[k], wd_q[k], 18'(18'h204 + k), want[k % 4]);
            else n_pass++;
        end
    endtask

    task automatic test_threshold_boundary();
        int na, fc; bit to;
        logic [11:0] thr;
        logic [31:0] w1, w2;
        for (int k = 0; k < 16; k++) img_w[k] = (k % 4 < 2) ? 32'h0 : 32'h05050505;
        lat = 1; lat_rand = 1'b0;
        for (int t = 0; t < 2; t++) begin
            thr = (t == 0) ? 12'd20 : 12'd19;
            w1 = (t == 0) ? 32'h0 : 32'hFF000000;
            w2 = (t == 0) ? 32'h0 : 32'h000000FF;
            run_frame(18'h100, 18'h200, thr, 1'b0, na, fc, to);
            n_total++; if (wa_q.size() != 8) $display("FAIL thr_nwrites got %0d want 8", wa_q.size()); else n_pass++;
            for (int k = 0; k < wa_q.size(); k++) begin
                if (k % 4 == 1 || k % 4 == 2) begin
                    n_total++;
                    if (wd_q[k] !== ((k % 4 == 1) ? w1 : w2))
                        $display("FAIL thr_%0d_word got %h want %h", thr, wd_q[k], (k % 4 == 1) ? w1 : w2);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int na, fc; bit to;
        logic [31:0] want [4];
        want[0] = 32'h0; want[1] = 32'hFF000000; want[2] = 32'h000000FF; want[3] = 32'h0;
        for (int k = 0; k < 16; k++) img_w[k] = (k % 4 < 2) ? 32'h0 : 32'hFFFFFFFF;
        lat = 3; lat_rand = 1'b0;
        run_frame(18'h100, 18'h200, 12'd10, 1'b1, na, fc, to);
        n_total++; if (to) $display("FAIL slow_timeout got busy stuck want fall"); else n_pass++;
        n_total++; if (stab_err != 0) $display("FAIL slow_stability got %0d changes want 0", stab_err); else n_pass++;
        n_total++; if (drop_err != 0) $display("FAIL slow_req_drop got %0d want 0", drop_err); else n_pass++;
        n_total++; if (na != 1) $display("FAIL slow_ack_pulses got %0d want 1", na); else n_pass++;
        n_total++;
        if (rd_q.size() + wa_q.size() != 24) $display("FAIL slow_txn_count got %0d want 24", rd_q.size() + wa_q.size());
        else n_pass++;
        for (int k = 0; k < wd_q.size(); k++) begin
            n_total++;
            if (wd_q[k] !== want[k % 4]) $display("FAIL slow_wdata got %h want %h", wd_q[k], want[k % 4]);
            else n_pass++;
        end
        n_total++; if (fc != last_wr_cyc + 1) $display("FAIL slow_busy_fall got %0d want %0d", fc, last_wr_cyc + 1); else n_pass++;
    endtask

    task automatic test_addr_wrap();
        int na, fc; bit to;
        for (int k = 0; k < 16; k++) img_w[k] = $urandom;
        lat = 1; lat_rand = 1'b0;
        run_frame(18'h3FFFE, 18'h3FFFA, 12'd200, 1'b0, na, fc, to);
        n_total++; if (rd_q.size() != 16) $display("FAIL wrap_nreads got %0d want 16", rd_q.size()); else n_pass++;
        for (int k = 0; k < rd_q.size(); k++) begin
            n_total++;
            if (rd_q[k] !== 18'(18'h3FFFE + k)) $display("FAIL wrap_raddr got %h want %h", rd_q[k], 18'(18'h3FFFE + k));
            else n_pass++;
        end
        for (int k = 0; k < wa_q.size(); k++) begin
            n_total++;
            if (wa_q[k] !== 18'(18'h3FFFE + k) || wd_q[k] !== exp_word(1 + k/4, k%4, 12'd200))
                $display("FAIL wrap_write got %h:%h want %h:%h", wa_q[k], wd_q[k], 18'(18'h3FFFE + k), exp_word(1 + k/4, k%4, 12'd200));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int na, fc; bit to;
        logic [AW-1:0] src, dst;
        logic [11:0] thr;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 16; k++) img_w[k] = $urandom;
            src = 18'($urandom); dst = 18'($urandom); thr = 12'($urandom_range(0, 900));
            lat_rand = 1'b1;
            run_frame(src, dst, thr, 1'b0, na, fc, to);
            n_total++;
            if (rd_q.size() != 16 || wa_q.size() != 8 || to)
                $display("FAIL rand_counts got %0d/%0d want 16/8", rd_q.size(), wa_q.size());
            else n_pass++;
            for (int k = 0; k < wa_q.size(); k++) begin
                n_total++;
                if (wa_q[k] !== 18'(dst + 18'd4 + 18'(k)) || wd_q[k] !== exp_word(1 + k/4, k%4, thr))
                    $display("FAIL rand_write got %h:%h want %h:%h", wa_q[k], wd_q[k], 18'(dst + 18'd4 + 18'(k)), exp_word(1 + k/4, k%4, thr));
                else n_pass++;
            end
            n_total++;
            if (stab_err + drop_err + nb_err != 0) $display("FAIL rand_handshake got %0d/%0d/%0d want 0/0/0", stab_err, drop_err, nb_err);
            else n_pass++;
        end
        lat_rand = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int na, fc, reqs; bit to, found;
        for (int k = 0; k < 16; k++) img_w[k] = $urandom;
        lat = 3; lat_rand = 1'b0;
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        cur_src = 18'h100;
        @(negedge clk);
        src_base = 18'h100; dst_base = 18'h200; threshold = 12'd100; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (de_req && !de_rnw && de_addr == 18'h206) begin
                found = 1'b1;
                break;
            end
        end
        n_total++; if (!found) $display("FAIL rstmid_third_write got none want write at 206"); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (de_req !== 1'b0) $display("FAIL rstmid_de_req got %b want 0", de_req); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
        n_total++; if (ack !== 1'b0) $display("FAIL rstmid_ack got %b want 0", ack); else n_pass++;
        reqs = 0;
        repeat (3) begin
            @(negedge clk);
            if (de_req) reqs++;
        end
        n_total++; if (reqs != 0) $display("FAIL rstmid_quiet got %0d requests want 0", reqs); else n_pass++;
        rst_n = 1'b1;
        lat = 1;
        repeat (2) @(negedge clk);
        run_frame(18'h100, 18'h200, 12'd100, 1'b0, na, fc, to);
        n_total++;
        if (rd_q.size() == 0 || rd_q[0] !== 18'h100) $display("FAIL rstmid_restart got %0d reads want first at 100", rd_q.size());
        else n_pass++;
        n_total++; if (wa_q.size() != 8) $display("FAIL rstmid_nwrites got %0d want 8", wa_q.size()); else n_pass++;
        for (int k = 0; k < wa_q.size(); k++) begin
            n_total++;
            if (wd_q[k] !== exp_word(1 + k/4, k%4, 12'd100))
                $display("FAIL rstmid_wdata got %h want %h", wd_q[k], exp_word(1 + k/4, k%4, 12'd100));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_vertical_step();
        test_threshold_boundary();
        test_back_to_back();
        test_addr_wrap();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
